// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers, with packet lock.
// Latency: req_valid sampled at edge k -> tx_start high after edge k; every output is registered.
// Backpressure: a requester holds valid/data until its one-cycle req_ready; nothing is granted while tx_busy=1.
module uart_tx_scheduler #(
    parameter int NUM_REQ       = 2,
    parameter int START_TIMEOUT = 16,
    parameter int LOCK_WAIT     = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic [NUM_REQ-1:0]   i_req_valid,
    input  logic [8*NUM_REQ-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]   i_req_last,
    output logic [NUM_REQ-1:0]   o_req_ready,
    output logic                 o_tx_start,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    output logic [1:0]           o_grant_id,
    output logic                 o_active,
    output logic                 o_start_err
);

    localparam int CNT_MAX = (START_TIMEOUT > LOCK_WAIT) ? START_TIMEOUT : LOCK_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [1:0] LAST_IDX = 2'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_HOLD} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [1:0]           r_rr;
    logic [1:0]           r_grant;
    logic                 r_lock;
    logic [CW-1:0]        r_cnt;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic [NUM_REQ-1:0]   r_req_ready;
    logic                 r_active;
    logic                 r_start_err;

    // Requester buses widened to the 4-requester maximum so a 2-bit index always fits exactly.
    logic [3:0]  w_v4;
    logic [3:0]  w_l4;
    logic [31:0] w_d4;
    logic [1:0]  w_winner;
    logic        w_any;
    logic [2:0]  w_sum;
    logic [1:0]  w_sel;
    logic [7:0]  w_byte;
    logic        w_valid_g;
    logic        w_last_g;
    logic [1:0]  w_next_rr;
    logic        w_issue;
    logic        w_ack;
    logic        w_tmo;
    logic        w_lock_exp;

    assign w_v4      = 4'(i_req_valid);
    assign w_l4      = 4'(i_req_last);
    assign w_d4      = 32'(i_req_data);
    assign w_sel     = (r_state == S_IDLE) ? w_winner : r_grant;
    assign w_byte    = w_d4[{w_sel, 3'b000} +: 8];
    assign w_valid_g = w_v4[r_grant];
    assign w_last_g  = w_l4[r_grant];
    assign w_next_rr = (r_grant == LAST_IDX) ? 2'd0 : r_grant + 2'd1;

    // Round-robin pick: scan offsets from the far end so the nearest valid requester at/after r_rr wins.
    always_comb begin
        w_any    = 1'b0;
        w_winner = r_rr;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + 3'(k);
            if (w_sum >= 3'(NUM_REQ)) begin
                w_sum = w_sum - 3'(NUM_REQ);
            end
            if (w_v4[w_sum[1:0]]) begin
                w_any    = 1'b1;
                w_winner = w_sum[1:0];
            end
        end
    end

    // Event decode shared by next-state and register logic; a byte is only issued to an idle transmitter.
    always_comb begin
        w_issue    = !i_tx_busy && (((r_state == S_IDLE) && w_any) || ((r_state == S_HOLD) && w_valid_g));
        w_ack      = (r_state == S_START) && i_tx_busy;
        w_tmo      = (r_state == S_START) && !i_tx_busy && (r_cnt == CW'(START_TIMEOUT - 1));
        w_lock_exp = (r_state == S_HOLD) && !w_valid_g && (r_cnt == CW'(LOCK_WAIT - 1));
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (w_issue) w_next = S_START;
            S_START:     if (w_ack) w_next = S_WAIT_DONE;
                         else if (w_tmo) w_next = S_IDLE;
            S_WAIT_DONE: if (!i_tx_busy) w_next = r_lock ? S_HOLD : S_IDLE;
            S_HOLD:      if (w_issue) w_next = S_START;
                         else if (w_lock_exp) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // Registered outputs, arbitration pointer, lock flag and the shared START/HOLD cycle counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_rr        <= '0;
            r_grant     <= '0;
            r_lock      <= 1'b0;
            r_cnt       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_data   <= '0;
            r_req_ready <= '0;
            r_active    <= 1'b0;
            r_start_err <= 1'b0;
        end else begin
            r_req_ready <= '0;
            r_start_err <= 1'b0;
            r_active    <= (w_next != S_IDLE);
            case (r_state)
                S_IDLE, S_HOLD: begin
                    if (w_issue) begin
                        r_grant    <= w_sel;
                        r_tx_data  <= w_byte;
                        r_tx_start <= 1'b1;
                        r_cnt      <= '0;
                    end else if (r_state == S_HOLD) begin
                        if (w_valid_g) begin
                            r_cnt <= '0;
                        end else if (w_lock_exp) begin
                            r_lock <= 1'b0;
                            r_rr   <= w_next_rr;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_START: begin
                    if (w_ack) begin
                        r_tx_start  <= 1'b0;
                        r_req_ready <= NUM_REQ'(4'b0001 << r_grant);
                        r_lock      <= !w_last_g;
                    end else if (w_tmo) begin
                        // Byte stays with its requester and is retried from IDLE.
                        r_tx_start  <= 1'b0;
                        r_start_err <= 1'b1;
                        r_lock      <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (r_lock) begin
                            r_cnt <= '0;
                        end else begin
                            r_rr <= w_next_rr;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = r_req_ready;
    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_grant_id  = r_grant;
    assign o_active    = r_active;
    assign o_start_err = r_start_err;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: randomized requester traffic against a packet-level round-robin model,
// plus directed scenarios for latency, lock timeout, start timeout and reset mid-frame.
// A behavioural transmitter raises tx_busy a random delay after tx_start and holds it a random length.
module tb_uart_tx_scheduler;
    localparam int NR = 2;
    localparam int ST = 16;
    localparam int LW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            active;
    logic            start_err;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Transmitter model controls: mode 0 copies tx_force, mode 1 responds to tx_start on its own.
    int   tx_mode   = 0;
    logic tx_force  = 1'b0;
    int   busy_left = 0;
    int   ack_delay = 0;

    byte unsigned qd[NR][$];
    bit           ql[NR][$];
    int           exp_r[$];
    byte unsigned exp_d[$];

    always #5 clk = ~clk;

    uart_tx_scheduler #(.NUM_REQ(NR), .START_TIMEOUT(ST), .LOCK_WAIT(LW)) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_req_valid (req_valid),
        .i_req_data  (req_data),
        .i_req_last  (req_last),
        .o_req_ready (req_ready),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .i_tx_busy   (tx_busy),
        .o_grant_id  (grant_id),
        .o_active    (active),
        .o_start_err (start_err)
    );

    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (tx_mode == 0) begin
                tx_busy   = tx_force;
                busy_left = 0;
                ack_delay = 0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy   = 1'b0;
                    ack_delay = $urandom_range(0, 2);
                end
            end else if (tx_start === 1'b1) begin
                if (ack_delay == 0) begin
                    tx_busy   = 1'b1;
                    busy_left = $urandom_range(3, 6);
                end else begin
                    ack_delay--;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        tx_mode = 0; tx_force = 1'b0;
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        req_valid = '0;
        while ((active !== 1'b0 || tx_busy !== 1'b0) && k < 100) begin
            @(negedge clk); k++;
        end
        chk_cnt++;
        if (active !== 1'b0) $display("FAIL drain_idle: active=%b expected 0", active);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b expected 0", tx_start); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h expected 00", tx_data); else pass_cnt++;
        chk_cnt++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else pass_cnt++;
        chk_cnt++; if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d expected 0", grant_id); else pass_cnt++;
        chk_cnt++; if (active !== 1'b0) $display("FAIL reset_active: got %b expected 0", active); else pass_cnt++;
        chk_cnt++; if (start_err !== 1'b0) $display("FAIL reset_start_err: got %b expected 0", start_err); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        logic [NR-1:0] seen;
        int k, extra;
        do_reset();
        tx_mode = 1;
        req_data = {8'($urandom), 8'h55}; req_last = 2'b01; req_valid = 2'b01;
        @(negedge clk);
        chk_cnt++; if (tx_start !== 1'b1) $display("FAIL single_latency: tx_start=%b expected 1", tx_start); else pass_cnt++;
        chk_cnt++; if (tx_data !== 8'h55) $display("FAIL single_data: tx_data=%h expected 55", tx_data); else pass_cnt++;
        seen = '0; k = 0;
        while (seen == '0 && k < 30) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        chk_cnt++; if (seen !== 2'b01) $display("FAIL single_ready: req_ready=%b expected 01", seen); else pass_cnt++;
        req_valid = '0;
        extra = 0; k = 0;
        while (tx_busy !== 1'b0 && k < 30) begin
            @(negedge clk); k++;
            if (req_ready != '0) extra++;
        end
        chk_cnt++; if (active !== 1'b0) $display("FAIL single_active_end: active=%b expected 0", active); else pass_cnt++;
        chk_cnt++; if (extra !== 0) $display("FAIL single_ready_once: extra pulses=%0d expected 0", extra); else pass_cnt++;
    endtask

    // Random packets per requester, every requester presenting continuously; expected order from packet-level RR.
    task automatic test_traffic(input bit lock_en, input string name);
        byte unsigned cd[NR][$];
        bit           cl[NR][$];
        int p, w, cyc, npk, len;
        bit l;
        byte unsigned d;
        logic [NR-1:0] want;
        do_reset();
        tx_mode = 1;
        exp_r.delete(); exp_d.delete();
        for (int r = 0; r < NR; r++) begin
            qd[r].delete(); ql[r].delete();
            npk = $urandom_range(3, 6);
            for (int pk = 0; pk < npk; pk++) begin
                len = lock_en ? $urandom_range(1, 3) : 1;
                for (int b = 0; b < len; b++) begin
                    qd[r].push_back(8'($urandom));
                    ql[r].push_back(b == len - 1);
                end
            end
            cd[r] = qd[r]; cl[r] = ql[r];
        end
        p = 0;
        forever begin
            w = -1;
            for (int k = 0; k < NR; k++) begin
                if (cd[(p + k) % NR].size() > 0) begin
                    w = (p + k) % NR;
                    break;
                end
            end
            if (w < 0) break;
            do begin
                d = cd[w].pop_front(); l = cl[w].pop_front();
                exp_r.push_back(w); exp_d.push_back(d);
            end while (!l);
            p = (w + 1) % NR;
        end
        cyc = 0;
        while (exp_r.size() > 0 && cyc < 4000) begin
            for (int r = 0; r < NR; r++) begin
                req_valid[r] = (qd[r].size() > 0);
                req_data[8*r +: 8] = (qd[r].size() > 0) ? qd[r][0] : 8'h00;
                req_last[r] = (ql[r].size() > 0) ? ql[r][0] : 1'b0;
            end
            @(negedge clk); cyc++;
            if (req_ready != '0) begin
                want = NR'(1) << exp_r[0];
                chk_cnt++;
                if (req_ready !== want)
                    $display("FAIL %s_ready: req_ready=%b expected %b", name, req_ready, want);
                else pass_cnt++;
                chk_cnt++;
                if (grant_id !== 2'(exp_r[0]) || tx_data !== exp_d[0])
                    $display("FAIL %s_byte: grant=%0d data=%h expected grant=%0d data=%h",
                             name, grant_id, tx_data, exp_r[0], exp_d[0]);
                else pass_cnt++;
                void'(exp_r.pop_front()); void'(exp_d.pop_front());
                for (int r = 0; r < NR; r++) begin
                    if (req_ready[r] && qd[r].size() > 0) begin
                        void'(qd[r].pop_front()); void'(ql[r].pop_front());
                    end
                end
            end
        end
        chk_cnt++;
        if (exp_r.size() != 0) $display("FAIL %s_complete: %0d bytes outstanding expected 0", name, exp_r.size());
        else pass_cnt++;
        drain();
    endtask

    task automatic test_lock_timeout();
        logic [NR-1:0] seen;
        int k, n;
        do_reset();
        tx_mode = 1;
        req_data = {8'hB2, 8'hA1}; req_last = 2'b10; req_valid = 2'b11;
        seen = '0; k = 0;
        while (seen == '0 && k < 40) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        chk_cnt++; if (seen !== 2'b01) $display("FAIL lockto_first: req_ready=%b expected 01", seen); else pass_cnt++;
        req_valid = 2'b10;
        k = 0;
        while (tx_busy !== 1'b0 && k < 20) begin
            @(negedge clk); k++;
        end
        n = 0;
        while (tx_start !== 1'b1 && n < 100) begin
            @(negedge clk); n++;
        end
        chk_cnt++; if (n != LW + 1) $display("FAIL lockto_delay: cycles=%0d expected %0d", n, LW + 1); else pass_cnt++;
        chk_cnt++;
        if (grant_id !== 2'd1 || tx_data !== 8'hB2)
            $display("FAIL lockto_next: grant=%0d data=%h expected grant=1 data=b2", grant_id, tx_data);
        else pass_cnt++;
        seen = '0; k = 0;
        while (seen == '0 && k < 40) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        drain();
    endtask

    task automatic test_start_timeout();
        int n_hi, n_rdy, k;
        logic [NR-1:0] seen;
        do_reset();
        req_data = {8'h00, 8'h3C}; req_last = 2'b01; req_valid = 2'b01;
        n_hi = 0; n_rdy = 0; k = 0;
        while (start_err !== 1'b1 && k < 60) begin
            @(negedge clk); k++;
            if (tx_start === 1'b1) n_hi++;
            if (req_ready != '0) n_rdy++;
        end
        chk_cnt++; if (start_err !== 1'b1) $display("FAIL stmo_err: start_err=%b expected 1", start_err); else pass_cnt++;
        chk_cnt++; if (n_hi != ST) $display("FAIL stmo_cycles: tx_start cycles=%0d expected %0d", n_hi, ST); else pass_cnt++;
        chk_cnt++; if (n_rdy != 0 || tx_start !== 1'b0)
            $display("FAIL stmo_abort: ready pulses=%0d tx_start=%b expected 0 and 0", n_rdy, tx_start);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (start_err !== 1'b0 || tx_start !== 1'b1 || tx_data !== 8'h3C)
            $display("FAIL stmo_retry: err=%b tx_start=%b data=%h expected 0 1 3c", start_err, tx_start, tx_data);
        else pass_cnt++;
        tx_mode = 1;
        seen = '0; k = 0;
        while (seen == '0 && k < 40) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        chk_cnt++; if (seen !== 2'b01) $display("FAIL stmo_done: req_ready=%b expected 01", seen); else pass_cnt++;
        drain();
    endtask

    task automatic test_reset_mid();
        int k, n_hi;
        logic [NR-1:0] seen;
        do_reset();
        req_data = {8'h00, 8'h77}; req_last = 2'b01; req_valid = 2'b01;
        k = 0;
        while (tx_start !== 1'b1 && k < 10) begin
            @(negedge clk); k++;
        end
        tx_force = 1'b1;
        seen = '0; k = 0;
        while (seen == '0 && k < 10) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        rst = 1'b1;
        @(negedge clk);
        chk_cnt++;
        if ({tx_start, tx_data, req_ready, grant_id, active, start_err} !== '0)
            $display("FAIL rstmid_outputs: start=%b data=%h ready=%b grant=%0d active=%b err=%b expected all 0",
                     tx_start, tx_data, req_ready, grant_id, active, start_err);
        else pass_cnt++;
        rst = 1'b0;
        n_hi = 0;
        repeat (10) begin
            @(negedge clk);
            if (tx_start !== 1'b0) n_hi++;
        end
        chk_cnt++; if (n_hi != 0) $display("FAIL rstmid_no_start: tx_start cycles=%0d expected 0", n_hi); else pass_cnt++;
        tx_force = 1'b0;
        k = 0;
        while (tx_start !== 1'b1 && k < 3) begin
            @(negedge clk); k++;
        end
        chk_cnt++;
        if (tx_start !== 1'b1 || tx_data !== 8'h77)
            $display("FAIL rstmid_resume: tx_start=%b data=%h expected 1 77", tx_start, tx_data);
        else pass_cnt++;
        tx_mode = 1;
        seen = '0; k = 0;
        while (seen == '0 && k < 40) begin
            @(negedge clk); k++;
            seen = req_ready;
        end
        drain();
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
        test_reset();
        test_single();
        test_traffic(1'b0, "round_robin");
        test_traffic(1'b1, "lock");
        test_lock_timeout();
        test_start_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
